// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter (mem_port_arbiter).
package mem_port_arbiter_pkg;

    localparam int INSTR_W    = 32;
    localparam int MEM_ADDR_W = 64;
    localparam int MEM_DATA_W = 64;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_ADDR = 3'd1,
        D_DATA = 3'd2,
        I_ADDR = 3'd3,
        I_DATA = 3'd4
    } arb_state_t;

    typedef struct packed {
        logic                    write;
        logic [MEM_ADDR_W-1:0]   addr;
        logic [MEM_DATA_W/8-1:0] strobe;
        logic [MEM_DATA_W-1:0]   wdata;
    } mem_req_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        if (en && (v != 32'hFFFF_FFFF)) begin
            return v + 32'd1;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/mem_arb_fetch_buf.sv
// Holds a completed fetch (i_done/ibuf) until the F stage advances, and selects
// the 32-bit instruction word out of the memory data beat.
module mem_arb_fetch_buf
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               resp,
    input  logic               sel_hi,
    input  logic [DATA_W-1:0]  rdata,
    input  logic               f_adv,
    output logic               i_done,
    output logic [INSTR_W-1:0] word
);

    logic               i_done_r;
    logic [INSTR_W-1:0] ibuf_r;
    logic [INSTR_W-1:0] sel_word_s;

    assign sel_word_s = sel_hi ? rdata[INSTR_W +: INSTR_W] : rdata[INSTR_W-1:0];

    // Done flag and buffered word; an F advance clears the flag even if a response lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_done_r <= 1'b0;
            ibuf_r   <= {INSTR_W{1'b0}};
        end else begin
            if (f_adv) begin
                i_done_r <= 1'b0;
            end else if (resp) begin
                i_done_r <= 1'b1;
            end else begin
                i_done_r <= i_done_r;
            end
            if (resp) begin
                ibuf_r <= sel_word_s;
            end else begin
                ibuf_r <= ibuf_r;
            end
        end
    end

    assign i_done = i_done_r;
    assign word   = resp ? sel_word_s : ibuf_r;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between fetch (F) and data (M) requesters, data first.
// Optional build macro MEM_ARB_STATS_EN adds saturating wait/conflict counters.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ireq_valid,
    input  logic [ADDR_W-1:0]   ireq_addr,
    output logic [INSTR_W-1:0]  iresp_data,
    output logic                i_data_ok,
    input  logic                dreq_valid,
    input  logic                dreq_write,
    input  logic [ADDR_W-1:0]   dreq_addr,
    input  logic [DATA_W/8-1:0] dreq_strobe,
    input  logic [DATA_W-1:0]   dreq_wdata,
    output logic [DATA_W-1:0]   dresp_data,
    output logic                d_data_ok,
    input  logic                f_hold,
    output logic                m_req,
    output logic                m_write,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W/8-1:0] m_strobe,
    output logic [DATA_W-1:0]   m_wdata,
`ifdef MEM_ARB_STATS_EN
    output logic [31:0]         stat_i_wait,
    output logic [31:0]         stat_d_wait,
    output logic [31:0]         stat_conflict,
`endif
    input  logic                m_addr_ok,
    input  logic                m_data_ok,
    input  logic [DATA_W-1:0]   m_rdata
);

    arb_state_t        state_r, state_s;
    mem_req_t          req_r, req_s;
    logic              m_req_r;
    logic [DATA_W-1:0] dresp_r;
    logic              d_resp_s, i_resp_s, i_pend_s, i_done_s, f_adv_s;

    // A response may coincide with address acceptance; treat it as completing right away.
    assign d_resp_s = m_data_ok & ((state_r == D_DATA) | ((state_r == D_ADDR) & m_addr_ok));
    assign i_resp_s = m_data_ok & ((state_r == I_DATA) | ((state_r == I_ADDR) & m_addr_ok));
    assign i_pend_s = ireq_valid & ~i_done_s;

    assign d_data_ok = ~dreq_valid | d_resp_s;
    assign i_data_ok = ~ireq_valid | i_done_s | i_resp_s;
    assign f_adv_s   = i_data_ok & d_data_ok & ~f_hold;

    // Next-state and request capture; fields are frozen for the whole address phase.
    always_comb begin
        state_s = state_r;
        req_s   = req_r;
        case (state_r)
            IDLE: begin
                if (dreq_valid) begin
                    state_s      = D_ADDR;
                    req_s.write  = dreq_write;
                    req_s.addr   = MEM_ADDR_W'(dreq_addr);
                    req_s.strobe = (MEM_DATA_W/8)'(dreq_strobe);
                    req_s.wdata  = MEM_DATA_W'(dreq_wdata);
                end else if (i_pend_s) begin
                    state_s      = I_ADDR;
                    req_s.write  = 1'b0;
                    req_s.addr   = MEM_ADDR_W'(ireq_addr);
                    req_s.strobe = {(MEM_DATA_W/8){1'b0}};
                    req_s.wdata  = {MEM_DATA_W{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            D_ADDR, D_DATA: begin
                if (d_resp_s) begin
                    if (i_pend_s) begin
                        state_s      = I_ADDR;
                        req_s.write  = 1'b0;
                        req_s.addr   = MEM_ADDR_W'(ireq_addr);
                        req_s.strobe = {(MEM_DATA_W/8){1'b0}};
                        req_s.wdata  = {MEM_DATA_W{1'b0}};
                    end else begin
                        state_s = IDLE;
                    end
                end else if ((state_r == D_ADDR) && m_addr_ok) begin
                    state_s = D_DATA;
                end else begin
                    state_s = state_r;
                end
            end
            I_ADDR, I_DATA: begin
                if (i_resp_s) begin
                    state_s = IDLE;
                end else if ((state_r == I_ADDR) && m_addr_ok) begin
                    state_s = I_DATA;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, registered memory request and last load data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
            req_r   <= '0;
            m_req_r <= 1'b0;
            dresp_r <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_s;
            req_r   <= req_s;
            m_req_r <= (state_s == D_ADDR) || (state_s == I_ADDR);
            if (d_resp_s) begin
                dresp_r <= m_rdata;
            end else begin
                dresp_r <= dresp_r;
            end
        end
    end

    assign m_req      = m_req_r;
    assign m_write    = req_r.write;
    assign m_addr     = req_r.addr[ADDR_W-1:0];
    assign m_strobe   = req_r.strobe[DATA_W/8-1:0];
    assign m_wdata    = req_r.wdata[DATA_W-1:0];
    assign dresp_data = d_resp_s ? m_rdata : dresp_r;

    mem_arb_fetch_buf #(.DATA_W(DATA_W)) u_fetch_buf (
        .clk    (clk),
        .rst_n  (resetn),
        .resp   (i_resp_s),
        .sel_hi (ireq_addr[2]),
        .rdata  (m_rdata),
        .f_adv  (f_adv_s),
        .i_done (i_done_s),
        .word   (iresp_data)
    );

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_i_r, stat_d_r, stat_c_r;

    // Saturating stall and conflict counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_i_r <= 32'd0;
            stat_d_r <= 32'd0;
            stat_c_r <= 32'd0;
        end else begin
            stat_i_r <= sat_inc(stat_i_r, ~i_data_ok);
            stat_d_r <= sat_inc(stat_d_r, ~d_data_ok);
            stat_c_r <= sat_inc(stat_c_r, (state_r == IDLE) & dreq_valid & i_pend_s);
        end
    end

    assign stat_i_wait   = stat_i_r;
    assign stat_d_wait   = stat_d_r;
    assign stat_conflict = stat_c_r;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; drives the memory side by hand.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic [31:0] iresp_data;
    logic        i_data_ok;
    logic        dreq_valid, dreq_write;
    logic [63:0] dreq_addr;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_wdata;
    logic [63:0] dresp_data;
    logic        d_data_ok;
    logic        f_hold;
    logic        m_req, m_write;
    logic [63:0] m_addr;
    logic [7:0]  m_strobe;
    logic [63:0] m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [63:0] m_rdata;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_i_wait, stat_d_wait, stat_conflict;
`endif

    int vecs  = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .resetn(resetn),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .iresp_data(iresp_data), .i_data_ok(i_data_ok),
        .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
        .dreq_strobe(dreq_strobe), .dreq_wdata(dreq_wdata), .dresp_data(dresp_data), .d_data_ok(d_data_ok),
        .f_hold(f_hold),
        .m_req(m_req), .m_write(m_write), .m_addr(m_addr), .m_strobe(m_strobe), .m_wdata(m_wdata),
`ifdef MEM_ARB_STATS_EN
        .stat_i_wait(stat_i_wait), .stat_d_wait(stat_d_wait), .stat_conflict(stat_conflict),
`endif
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ireq_valid = 1'b0; ireq_addr = 64'd0;
        dreq_valid = 1'b0; dreq_write = 1'b0; dreq_addr = 64'd0;
        dreq_strobe = 8'd0; dreq_wdata = 64'd0;
        f_hold = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 64'd0;
    endtask

    task automatic test_reset;
        idle_inputs();
        resetn = 1'b0;
        nxt(); nxt();
        @(negedge clk);
        vecs++; if (m_req !== 1'b0) begin fails++; $display("FAIL reset_m_req got %b want 0", m_req); end
        vecs++; if ({m_write, m_addr, m_strobe, m_wdata} !== 137'd0) begin fails++; $display("FAIL reset_m_fields got %h want 0", {m_write, m_addr, m_strobe, m_wdata}); end
        vecs++; if (iresp_data !== 32'd0 || dresp_data !== 64'd0) begin fails++; $display("FAIL reset_resp got %h/%h want 0/0", iresp_data, dresp_data); end
        vecs++; if (i_data_ok !== 1'b1 || d_data_ok !== 1'b1) begin fails++; $display("FAIL reset_oks got %b%b want 11", i_data_ok, d_data_ok); end
        nxt();
        resetn = 1'b1;
        nxt();
    endtask

    task automatic test_i_only;
        ireq_valid = 1'b1; ireq_addr = 64'h8000_0004;
        @(negedge clk);
        vecs++; if (i_data_ok !== 1'b0 || m_req !== 1'b0) begin fails++; $display("FAIL ionly_n got ok=%b req=%b want 0/0", i_data_ok, m_req); end
        nxt(); m_addr_ok = 1'b1;
        @(negedge clk);
        vecs++; if (m_req !== 1'b1 || m_addr !== 64'h8000_0004 || m_write !== 1'b0) begin fails++; $display("FAIL ionly_issue got req=%b addr=%h wr=%b want 1/80000004/0", m_req, m_addr, m_write); end
        nxt(); m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 64'h1111_2222_3333_4444;
        @(negedge clk);
        vecs++; if (i_data_ok !== 1'b1 || iresp_data !== 32'h1111_2222) begin fails++; $display("FAIL ionly_resp got ok=%b data=%h want 1/11112222", i_data_ok, iresp_data); end
        vecs++; if (m_req !== 1'b0) begin fails++; $display("FAIL ionly_req_drop got %b want 0", m_req); end
        nxt(); m_data_ok = 1'b0; ireq_valid = 1'b0;
        nxt();
    endtask

    task automatic test_i_d_tie;
        int  d_cyc = -1;
        int  i_cyc = -1;
        int  hs    = 0;
        logic pend = 1'b0;
        ireq_valid = 1'b1; ireq_addr = 64'h8000_0000;
        dreq_valid = 1'b1; dreq_write = 1'b0; dreq_addr = 64'h8000_1000;
        m_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        for (int c = 0; c < 8; c++) begin
            m_data_ok = pend;
            m_addr_ok = m_req;
            pend      = m_req;
            @(negedge clk);
            if (m_req && m_addr_ok) hs++;
            if (dreq_valid && d_data_ok && d_cyc < 0) begin
                d_cyc = c;
                vecs++; if (dresp_data !== 64'hAAAA_BBBB_CCCC_DDDD) begin fails++; $display("FAIL tie_dresp got %h want aaaabbbbccccdddd", dresp_data); end
            end
            if (ireq_valid && i_data_ok && i_cyc < 0) begin
                i_cyc = c;
                vecs++; if (iresp_data !== 32'hCCCC_DDDD) begin fails++; $display("FAIL tie_iresp got %h want ccccdddd", iresp_data); end
            end
            nxt();
            if (d_cyc >= 0) dreq_valid = 1'b0;
            if (i_cyc >= 0) ireq_valid = 1'b0;
        end
        m_addr_ok = 1'b0; m_data_ok = 1'b0;
        vecs++; if (d_cyc !== 2) begin fails++; $display("FAIL tie_d_cycle got %0d want 2", d_cyc); end
        vecs++; if (i_cyc !== 4) begin fails++; $display("FAIL tie_i_cycle got %0d want 4", i_cyc); end
        vecs++; if (hs !== 2) begin fails++; $display("FAIL tie_handshakes got %0d want 2", hs); end
    endtask

    task automatic test_f_hold;
        ireq_valid = 1'b1; ireq_addr = 64'h8000_0008; f_hold = 1'b1;
        @(negedge clk);
        vecs++; if (i_data_ok !== 1'b0) begin fails++; $display("FAIL hold_c0_ok got %b want 0", i_data_ok); end
        nxt(); m_addr_ok = 1'b1;
        @(negedge clk);
        vecs++; if (m_req !== 1'b1) begin fails++; $display("FAIL hold_issue got %b want 1", m_req); end
        nxt(); m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 64'h5555_6666_7777_8888;
        @(negedge clk);
        vecs++; if (i_data_ok !== 1'b1 || iresp_data !== 32'h7777_8888) begin fails++; $display("FAIL hold_resp got ok=%b data=%h want 1/77778888", i_data_ok, iresp_data); end
        for (int c = 3; c < 6; c++) begin
            nxt(); m_data_ok = 1'b0; m_rdata = 64'd0;
            if (c == 5) f_hold = 1'b0;
            @(negedge clk);
            vecs++; if (i_data_ok !== 1'b1 || iresp_data !== 32'h7777_8888 || m_req !== 1'b0) begin
                fails++; $display("FAIL hold_held c%0d got ok=%b data=%h req=%b want 1/77778888/0", c, i_data_ok, iresp_data, m_req);
            end
        end
        nxt(); ireq_addr = 64'h8000_000C;
        @(negedge clk);
        vecs++; if (i_data_ok !== 1'b0 || m_req !== 1'b0) begin fails++; $display("FAIL hold_cleared got ok=%b req=%b want 0/0", i_data_ok, m_req); end
        nxt(); m_addr_ok = 1'b1;
        @(negedge clk);
        vecs++; if (m_req !== 1'b1 || m_addr !== 64'h8000_000C) begin fails++; $display("FAIL hold_refetch got req=%b addr=%h want 1/8000000c", m_req, m_addr); end
        nxt(); m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 64'h9999_AAAA_BBBB_CCCC;
        @(negedge clk);
        vecs++; if (i_data_ok !== 1'b1 || iresp_data !== 32'h9999_AAAA) begin fails++; $display("FAIL hold_hi_word got ok=%b data=%h want 1/9999aaaa", i_data_ok, iresp_data); end
        nxt(); m_data_ok = 1'b0; ireq_valid = 1'b0;
        nxt();
    endtask

    task automatic test_store_wait;
        ireq_valid = 1'b1; ireq_addr = 64'h8000_0010;
        nxt(); m_addr_ok = 1'b1;
        nxt(); m_addr_ok = 1'b0;
        dreq_valid = 1'b1; dreq_write = 1'b1; dreq_addr = 64'h8000_2000;
        dreq_strobe = 8'h0F; dreq_wdata = 64'h0000_0000_DEAD_BEEF;
        @(negedge clk);
        vecs++; if (m_req !== 1'b0 || d_data_ok !== 1'b0) begin fails++; $display("FAIL store_waits got req=%b dok=%b want 0/0", m_req, d_data_ok); end
        nxt(); m_data_ok = 1'b1; m_rdata = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        vecs++; if (i_data_ok !== 1'b1 || iresp_data !== 32'h9ABC_DEF0 || m_req !== 1'b0) begin fails++; $display("FAIL store_iresp got ok=%b data=%h req=%b want 1/9abcdef0/0", i_data_ok, iresp_data, m_req); end
        nxt(); m_data_ok = 1'b0;
        nxt(); m_addr_ok = 1'b1;
        @(negedge clk);
        vecs++; if (m_req !== 1'b1 || m_write !== 1'b1 || m_strobe !== 8'h0F || m_wdata !== 64'h0000_0000_DEAD_BEEF || m_addr !== 64'h8000_2000) begin
            fails++; $display("FAIL store_issue got req=%b wr=%b strb=%h wd=%h addr=%h want 1/1/0f/deadbeef/80002000", m_req, m_write, m_strobe, m_wdata, m_addr);
        end
        nxt(); m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 64'd0;
        @(negedge clk);
        vecs++; if (d_data_ok !== 1'b1 || i_data_ok !== 1'b1) begin fails++; $display("FAIL store_done got dok=%b iok=%b want 1/1", d_data_ok, i_data_ok); end
        nxt(); m_data_ok = 1'b0; ireq_valid = 1'b0; dreq_valid = 1'b0; dreq_write = 1'b0; dreq_strobe = 8'd0;
        @(negedge clk);
        vecs++; if (m_req !== 1'b0) begin fails++; $display("FAIL store_after got req=%b want 0", m_req); end
        nxt();
    endtask

    task automatic test_addr_delay;
        dreq_valid = 1'b1; dreq_write = 1'b0; dreq_addr = 64'h8000_3000;
        for (int c = 1; c <= 4; c++) begin
            nxt();
            if (c == 2) dreq_addr = 64'h8000_3008;
            @(negedge clk);
            vecs++; if (m_req !== 1'b1 || m_addr !== 64'h8000_3000 || m_write !== 1'b0) begin
                fails++; $display("FAIL delay_stable c%0d got req=%b addr=%h wr=%b want 1/80003000/0", c, m_req, m_addr, m_write);
            end
        end
        nxt(); m_addr_ok = 1'b1;
        nxt(); m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 64'h0F0F_0F0F_F0F0_F0F0;
        @(negedge clk);
        vecs++; if (d_data_ok !== 1'b1 || dresp_data !== 64'h0F0F_0F0F_F0F0_F0F0) begin fails++; $display("FAIL delay_resp got ok=%b data=%h want 1/0f0f0f0ff0f0f0f0", d_data_ok, dresp_data); end
        nxt(); m_data_ok = 1'b0; dreq_valid = 1'b0;
        nxt();
    endtask

    task automatic test_reset_mid;
        dreq_valid = 1'b1; dreq_write = 1'b0; dreq_addr = 64'h8000_4000;
        nxt(); m_addr_ok = 1'b1;
        nxt(); m_addr_ok = 1'b0; resetn = 1'b0;
        @(negedge clk);
        vecs++; if (m_req !== 1'b0 || d_data_ok !== 1'b0 || i_data_ok !== 1'b1) begin fails++; $display("FAIL rstmid_oks got req=%b dok=%b iok=%b want 0/0/1", m_req, d_data_ok, i_data_ok); end
        vecs++; if (dresp_data !== 64'd0 || iresp_data !== 32'd0) begin fails++; $display("FAIL rstmid_resp got %h/%h want 0/0", dresp_data, iresp_data); end
`ifdef MEM_ARB_STATS_EN
        vecs++; if ({stat_i_wait, stat_d_wait, stat_conflict} !== 96'd0) begin fails++; $display("FAIL rstmid_stats got %h want 0", {stat_i_wait, stat_d_wait, stat_conflict}); end
`endif
        nxt(); resetn = 1'b1;
        nxt();
        @(negedge clk);
        vecs++; if (m_req !== 1'b1 || m_addr !== 64'h8000_4000) begin fails++; $display("FAIL rstmid_reissue got req=%b addr=%h want 1/80004000", m_req, m_addr); end
        m_addr_ok = 1'b1;
        nxt(); m_addr_ok = 1'b0; m_data_ok = 1'b1;
        nxt(); m_data_ok = 1'b0; dreq_valid = 1'b0;
        nxt();
    endtask

    initial begin
        test_reset();
        test_i_only();
        test_i_d_tie();
        test_f_hold();
        test_store_wait();
        test_addr_delay();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single memory port between the instruction-fetch side (F stage) and the data side (M stage). It produces `i_data_ok` and `d_data_ok`, which the hazard unit consumes as stall sources. It serialises requests with a small FSM and gives the data side priority. A completed fetch is held in a buffer until the F stage actually advances, so a data-side stall never forces a refetch.

Parameters:
ADDR_W, 64, address width of both requesters and the memory port
DATA_W, 64, memory port data width; the fetch word is 32 bits, selected by `ireq_addr[2]`

Ports:
clk  in  1  single clock
resetn  in  1  asynchronous active-low reset
ireq_valid  in  1  fetch request; address stable while `i_data_ok`=0
ireq_addr  in  ADDR_W  fetch address
iresp_data  out  32  fetched instruction word
i_data_ok  out  1  fetch satisfied, or no fetch request
dreq_valid  in  1  load/store request from M
dreq_write  in  1  1 = store
dreq_addr  in  ADDR_W  data address
dreq_strobe  in  DATA_W/8  store byte enables
dreq_wdata  in  DATA_W  store data
dresp_data  out  DATA_W  load data
d_data_ok  out  1  data access complete, or no data request
f_hold  in  1  non-memory F stall sources (lwstall|branchstall|~mult_ok)
m_req  out  1  memory request valid
m_write  out  1  memory write
m_addr  out  ADDR_W  memory address
m_strobe  out  DATA_W/8  memory byte enables
m_wdata  out  DATA_W  memory write data
m_addr_ok  in  1  request accepted
m_data_ok  in  1  response/write-ack valid (one cycle)
m_rdata  in  DATA_W  response data

Behaviour:
- FSM states: IDLE, D_ADDR, D_DATA, I_ADDR, I_DATA. Reset → IDLE, `i_done`=0, `ibuf`=0.
- Reset values of outputs: `m_req`=0, `m_write`=0, `m_addr`/`m_strobe`/`m_wdata`=0; `iresp_data`=0; `dresp_data`=0.
- IDLE transitions:
  - `dreq_valid` → D_ADDR.
  - Else `ireq_valid & ~i_done` → I_ADDR.
  - Data wins ties.
- Issue is registered: request fields are captured on entry to x_ADDR. `m_req`=1 throughout x_ADDR with fields constant.
  - x_ADDR → x_DATA when `m_addr_ok`.
  - If `m_addr_ok` and `m_data_ok` arrive in the same cycle, go straight to response handling.
- D_DATA with `m_data_ok`:
  - `d_data_ok`=1 and `dresp_data`=`m_rdata` combinationally that cycle.
  - Next state: I_ADDR if `ireq_valid & ~i_done`, else IDLE.
  - No D buffer is needed: M advances whenever `d_data_ok`=1.
- I_DATA with `m_data_ok`:
  - `i_data_ok`=1 and `iresp_data`=selected word that cycle.
  - If F does not advance, set `i_done` and latch `ibuf`.
  - Next state: IDLE.
- `d_data_ok` = `~dreq_valid` | (D_DATA & `m_data_ok`).
- `i_data_ok` = `~ireq_valid` | `i_done` | (I_DATA & `m_data_ok`).
- When `i_done`, `iresp_data` = `ibuf`.
- F advance = `i_data_ok` & `d_data_ok` & `~f_hold`. `i_done` clears on F advance; set and clear in the same cycle → clear.
- Minimum latency: request visible at cycle N → `m_req` at N+1 → ok at N+2, given `m_addr_ok` at N+1 and `m_data_ok` at N+2.
- A fetch is never issued while `i_done`=1.
- A D request arriving during an I transaction waits; the I transaction is never aborted.
- `resetn` low mid-transaction → immediate IDLE, `m_req`=0. The memory side shares `resetn`, so no stale response is expected.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined: adds outputs `stat_i_wait` (32b), `stat_d_wait` (32b) and `stat_conflict` (32b).
  - `stat_i_wait` counts cycles with `i_data_ok`=0.
  - `stat_d_wait` counts cycles with `d_data_ok`=0.
  - `stat_conflict` counts IDLE cycles where both requests are pending.
  - All counters saturate at all-ones and are reset to 0.
- Undefined: no counters, ports absent, behaviour otherwise identical.

Decomposition:
- Shared package (common): `arb_state_t` enum, a `mem_req_t` struct (`write`, `addr`, `strobe`, `wdata`), and an `INSTR_W`=32 constant.
- One sub-module, `mem_arb_fetch_buf`, holds the `i_done`/`ibuf` register pair, its set/clear logic and word select.

Test Plan:
- I-only: `ireq_addr`=0x8000_0004, memory responds 0x1111_2222_3333_4444 with zero-wait `m_addr_ok` and the following-cycle `m_data_ok` → `iresp_data`=0x1111_2222, `i_data_ok` at N+2.
- Simultaneous I+D load at 0x8000_1000 → D issued first; `d_data_ok` before `i_data_ok`; exactly 2 `m_req` handshakes.
- I completes while `f_hold`=1 for 3 cycles → `i_data_ok` stays 1, `iresp_data` held, no second fetch issued. `i_done` clears the cycle after `f_hold` drops.
- Store 0xDEAD_BEEF with strobe 0x0F while fetch is in I_DATA → store waits, then issues with `m_write`=1 and `m_strobe`=0x0F after the fetch response.
- `m_addr_ok` delayed 4 cycles → `m_req` and fields stable all 4 cycles.
- `resetn` pulsed low in D_DATA → `m_req`=0, state IDLE, both oks follow request valids; with MEM_ARB_STATS_EN, counters read 0.
